mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra RAM wait cycles per access; legal range 0..15.
REQ-002 Parameter ADDR_LIMIT, default 256, first out-of-range word address; used only under REQ-029.
REQ-003 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port clear  in  1  reset, synchronous, active-high.
REQ-005 Port req_read  in  1  read request from control unit.
REQ-006 Port req_write  in  1  write request from control unit.
REQ-007 Port addr  in  9  word address from MAR[8:0].
REQ-008 Port wdata  in  32  write data from MDR.
REQ-009 Port rdata  out  32  read data to MDR input mux.
REQ-010 Port busy  out  1  high while an access is in progress (ACCESS or DONE).
REQ-011 Port done  out  1  one-cycle completion pulse.
REQ-012 Port fault  out  1  one-cycle out-of-range pulse, coincident with done.
REQ-013 Port ram_read / ram_write  out  1 each  RAM strobes.
REQ-014 Port ram_addr  out  9, ram_wdata  out  32, ram_rdata  in  32: RAM address, write data, read data.

Function
REQ-015 FSM states IDLE, ACCESS and DONE; encoding is free.
REQ-016 IDLE: if req_write or req_read is high, latch addr/wdata, load wait count with WAIT_CYCLES, go to ACCESS; if both are high, the access is a write and the read is dropped.
REQ-017 ACCESS: ram_addr/ram_wdata driven from latched values; ram_write or ram_read held high for every ACCESS cycle, never both.
REQ-018 ACCESS with count nonzero: decrement count; with count zero: on a read, capture ram_rdata into rdata; go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-020 Latency: request sampled in IDLE at cycle N leads to done high in cycle N+WAIT_CYCLES+2; strobes high for WAIT_CYCLES+1 cycles.
REQ-021 rdata updates only on read completion and holds until the next read completes; writes leave rdata unchanged.
REQ-022 Requests are sampled only in IDLE; requests arriving in ACCESS or DONE are ignored, and latched addr/wdata stay unaffected by input changes.
REQ-023 Requester deasserts req in the done cycle; a req still high in the following IDLE cycle starts a new access (back-to-back).
REQ-024 busy = (state != IDLE); combinational from state.

Reset
REQ-025 clear high at a rising edge: state IDLE, count 0, rdata 0, latched addr/wdata 0; all outputs low except ram_addr/ram_wdata (0).
REQ-026 clear mid-access aborts it: strobes low from the next cycle; no done, no fault, rdata forced to 0.
REQ-027 clear has priority over any request sampled in the same cycle.

Configuration
REQ-028 Macro MEM_CTRL_RANGE_CHECK_EN selects address range checking.
REQ-029 With the macro defined, an access whose latched addr is >= ADDR_LIMIT still takes the full REQ-020 timing. For such an access: no RAM strobe is asserted; on a read, rdata is set to 0; fault pulses with done.
REQ-030 Without the macro: all addresses are accessed normally, fault is tied 0, and ADDR_LIMIT is unused.

Structure
REQ-031 Shared package mem_pkg: FSM state constants, WAIT_CYCLES default, address width 9, data width 32.
REQ-032 One sub-module, mem_wait_counter: loadable down-counter with zero flag; the FSM stays in mem_ctrl.
REQ-033 Instantiated in datapath between MAR/MDR and ram; rdata feeds the MDR mux; mem_read/mem_write become req_read/req_write.

Verification
REQ-034 Write sequence (WAIT_CYCLES=2): write 0xDEADBEEF to addr 0x05, then read addr 0x05. Required: ram_write high 3 cycles; done at N+4; read returns rdata=0xDEADBEEF at its done.
REQ-035 WAIT_CYCLES=0, read addr 0x1FF (RAM holds 0x12345678): ram_read high 1 cycle; done at N+2; rdata=0x12345678.
REQ-036 req_read and req_write high together, addr 0x10, wdata 0xA5A5A5A5: write performed, ram_read never high, rdata unchanged.
REQ-037 clear asserted in 2nd ACCESS cycle of a read: no done, strobes low next cycle, rdata=0; a new read afterwards completes normally.
REQ-038 Macro defined, ADDR_LIMIT=256, write 0x55 to addr 0x100: no ram_write, fault=done=1 at N+4; read of addr 0x100 gives rdata=0.
REQ-039 req_read held through done: second access starts the cycle after done; toggling addr during ACCESS does not change ram_addr.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory controller slice.
// State encoding, bus widths and the default RAM wait count.
package mem_pkg;

    localparam int ADDR_W          = 9;
    localparam int DATA_W          = 32;
    localparam int CNT_W           = 4;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int WAIT_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Control-unit and RAM side signals of the memory controller.
// master = requester/RAM side, slave = the controller itself.
interface mem_ctrl_if;
    import mem_pkg::*;

    logic  req_read;
    logic  req_write;
    addr_t addr;
    data_t wdata;
    data_t rdata;
    logic  busy;
    logic  done;
    logic  fault;
    logic  ram_read;
    logic  ram_write;
    addr_t ram_addr;
    data_t ram_wdata;
    data_t ram_rdata;

    modport master (
        output req_read,
        output req_write,
        output addr,
        output wdata,
        output ram_rdata,
        input  rdata,
        input  busy,
        input  done,
        input  fault,
        input  ram_read,
        input  ram_write,
        input  ram_addr,
        input  ram_wdata
    );

    modport slave (
        input  req_read,
        input  req_write,
        input  addr,
        input  wdata,
        input  ram_rdata,
        output rdata,
        output busy,
        output done,
        output fault,
        output ram_read,
        output ram_write,
        output ram_addr,
        output ram_wdata
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that paces RAM wait cycles.
// Saturates at zero; zero flag is combinational from the count.
module mem_wait_counter
    import mem_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Clear wins over load, load wins over decrement.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller between MAR/MDR and a synchronous-wait RAM.
// Optional macro MEM_CTRL_RANGE_CHECK_EN enables address range faults.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADDR_LIMIT  = 256
) (
    input  logic        clock,
    input  logic        clear,
    mem_ctrl_if.slave   bus
);

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > WAIT_CYCLES_MAX)) begin : g_bad_wait
        $error("mem_ctrl: WAIT_CYCLES out of range 0..15");
    end

    if (ADDR_LIMIT < 1) begin : g_bad_limit
        $error("mem_ctrl: ADDR_LIMIT must be positive");
    end

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t state;
    state_t state_n;

    addr_t lat_addr;
    data_t lat_wdata;
    logic  lat_write;
    data_t rdata_q;

    logic  start;
    logic  cnt_load;
    logic  cnt_dec;
    logic  cnt_zero;
    logic  strobe_en;
    logic  capture;
    logic  done_o;
    logic  access_ok;
    data_t rd_val;

    assign start = bus.req_read | bus.req_write;

    mem_wait_counter u_wait (
        .clock    (clock),
        .clear    (clear),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register; clear returns to IDLE and aborts any access.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-state controls.
    always_comb begin
        state_n   = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        strobe_en = 1'b0;
        capture   = 1'b0;
        done_o    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    state_n  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                strobe_en = 1'b1;
                if (cnt_zero) begin
                    capture = ~lat_write;
                    state_n = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Latch the request in IDLE so later input changes cannot leak in.
    // A simultaneous read+write is treated as a write.
    always_ff @(posedge clock) begin
        if (clear) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_write <= bus.req_write;
        end
    end

`ifdef MEM_CTRL_RANGE_CHECK_EN
    logic out_of_range;

    assign out_of_range = (int'({1'b0, lat_addr}) >= ADDR_LIMIT);
    assign access_ok    = ~out_of_range;
    assign rd_val       = out_of_range ? '0 : bus.ram_rdata;
    assign bus.fault    = done_o & out_of_range;
`else
    assign access_ok    = 1'b1;
    assign rd_val       = bus.ram_rdata;
    assign bus.fault    = 1'b0;
`endif

    // Read data register: updates only when a read completes.
    always_ff @(posedge clock) begin
        if (clear) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= rd_val;
        end
    end

    assign bus.ram_write = strobe_en & lat_write & access_ok;
    assign bus.ram_read  = strobe_en & ~lat_write & access_ok;
    assign bus.ram_addr  = lat_addr;
    assign bus.ram_wdata = lat_wdata;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl (two instances: 2 and 0 wait cycles).
// Transaction-timeline reference model with its own view of RAM contents.
module tb_mem_ctrl;
    import mem_pkg::*;

    localparam int NDUT = 2;

`ifdef MEM_CTRL_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clock     = 1'b0;
    logic        clear     = 1'b1;
    logic        req_read  = 1'b0;
    logic        req_write = 1'b0;
    logic [8:0]  addr      = '0;
    logic [31:0] wdata     = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] o_rdata  [NDUT];
    logic        o_busy   [NDUT];
    logic        o_done   [NDUT];
    logic        o_fault  [NDUT];
    logic        o_rd     [NDUT];
    logic        o_wr     [NDUT];
    logic [8:0]  o_raddr  [NDUT];
    logic [31:0] o_rwdata [NDUT];

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 511) return 32'h1234_5678;
        return (32'(i) * 32'h9E37_79B9) ^ 32'hC0FF_EE00;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_ctrl_if bus ();
        logic [31:0] ram [512];
        logic        ram_ready = 1'b0;

        assign bus.req_read  = req_read;
        assign bus.req_write = req_write;
        assign bus.addr      = addr;
        assign bus.wdata     = wdata;
        assign bus.ram_rdata = ram[bus.ram_addr];

        mem_ctrl #(
            .WAIT_CYCLES (g == 0 ? 2 : 0),
            .ADDR_LIMIT  (256)
        ) dut (
            .clock (clock),
            .clear (clear),
            .bus   (bus.slave)
        );

        always @(posedge clock) begin
            if (!ram_ready) begin
                for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
                ram_ready <= 1'b1;
            end else if (bus.ram_write) begin
                ram[bus.ram_addr] <= bus.ram_wdata;
            end
        end

        assign o_rdata[g]  = bus.rdata;
        assign o_busy[g]   = bus.busy;
        assign o_done[g]   = bus.done;
        assign o_fault[g]  = bus.fault;
        assign o_rd[g]     = bus.ram_read;
        assign o_wr[g]     = bus.ram_write;
        assign o_raddr[g]  = bus.ram_addr;
        assign o_rwdata[g] = bus.ram_wdata;
    end

    // Reference model: an accepted request at the end of cycle t0 owns
    // cycles t0+1 .. t0+W+2; strobes in the first W+1, done in the last.
    logic [31:0] mem_ref [NDUT][512];
    bit          have    [NDUT];
    int          t0      [NDUT];
    bit          m_wr    [NDUT];
    logic [8:0]  m_addr  [NDUT];
    logic [31:0] m_wdata [NDUT];
    logic [31:0] m_rdata [NDUT];
    bit          prev_clear = 1'b1;
    int          cyc = 0;

    always begin
        @(negedge clock);
        if (cyc == 0) begin
            for (int g = 0; g < NDUT; g++) begin
                for (int i = 0; i < 512; i++) mem_ref[g][i] = init_word(i);
                have[g]    = 1'b0;
                t0[g]      = 0;
                m_wr[g]    = 1'b0;
                m_addr[g]  = '0;
                m_wdata[g] = '0;
                m_rdata[g] = '0;
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            int    w;
            bit    oor, act, stb, dn;
            string p;
            w   = (g == 0) ? 2 : 0;
            p   = $sformatf("d%0d c%0d", g, cyc);
            oor = RANGE_EN && (int'(m_addr[g]) >= 256);
            act = have[g] && (cyc > t0[g]) && (cyc <= t0[g] + w + 2);
            stb = act && (cyc <= t0[g] + w + 1);
            dn  = have[g] && (cyc == t0[g] + w + 2);
            if (dn && !m_wr[g])
                m_rdata[g] = oor ? 32'h0 : mem_ref[g][m_addr[g]];
            check({p, " busy"}, 32'(o_busy[g]), 32'(act));
            check({p, " done"}, 32'(o_done[g]), 32'(dn));
            check({p, " fault"}, 32'(o_fault[g]), 32'(dn && oor));
            check({p, " ram_read"}, 32'(o_rd[g]), 32'(stb && !m_wr[g] && !oor));
            check({p, " ram_write"}, 32'(o_wr[g]), 32'(stb && m_wr[g] && !oor));
            check({p, " rdata"}, o_rdata[g], m_rdata[g]);
            if (stb && !oor)
                check({p, " ram_addr"}, 32'(o_raddr[g]), 32'(m_addr[g]));
            if (stb && m_wr[g] && !oor)
                check({p, " ram_wdata"}, o_rwdata[g], m_wdata[g]);
            if (prev_clear) begin
                check({p, " rst ram_addr"}, 32'(o_raddr[g]), 32'h0);
                check({p, " rst ram_wdata"}, o_rwdata[g], 32'h0);
            end
        end
        @(posedge clock);
        for (int g = 0; g < NDUT; g++) begin
            int w;
            w = (g == 0) ? 2 : 0;
            if (clear) begin
                have[g]    = 1'b0;
                m_rdata[g] = '0;
                m_addr[g]  = '0;
                m_wdata[g] = '0;
            end else if (!have[g] || (cyc >= t0[g] + w + 3)) begin
                if (req_read || req_write) begin
                    have[g]    = 1'b1;
                    t0[g]      = cyc;
                    m_wr[g]    = req_write;
                    m_addr[g]  = addr;
                    m_wdata[g] = wdata;
                    if (req_write && !(RANGE_EN && (int'(addr) >= 256)))
                        mem_ref[g][addr] = wdata;
                end
            end
        end
        prev_clear = clear;
        cyc++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic access(input bit wr, input bit rd,
                          input logic [8:0] a, input logic [31:0] d);
        req_write = wr;
        req_read  = rd;
        addr      = a;
        wdata     = d;
        step();
        req_write = 1'b0;
        req_read  = 1'b0;
        addr      = 9'(~a);
        step(7);
    endtask

    initial begin
        step(3);
        clear = 1'b0;
        step(2);
        access(1'b1, 1'b0, 9'h005, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 9'h005, 32'h0);
        access(1'b0, 1'b1, 9'h1FF, 32'h0);
        access(1'b1, 1'b1, 9'h010, 32'hA5A5_A5A5);
        req_read = 1'b1;
        addr     = 9'h020;
        step();
        req_read = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(5);
        access(1'b0, 1'b1, 9'h020, 32'h0);
        access(1'b1, 1'b0, 9'h100, 32'h0000_0055);
        access(1'b0, 1'b1, 9'h100, 32'h0);
        access(1'b0, 1'b1, 9'h005, 32'h0);
        req_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = 9'($urandom);
            step();
        end
        req_read = 1'b0;
        step(6);
        for (int i = 0; i < 800; i++) begin
            clear     = ($urandom_range(0, 59) == 0);
            req_read  = ($urandom_range(0, 2) == 0);
            req_write = ($urandom_range(0, 3) == 0);
            addr      = 9'($urandom);
            wdata     = $urandom;
            step();
        end
        clear     = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        step(8);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
